versat_axi_responder: RTL and testbench

//  AXI4 subordinate (responder) mapping AXI bursts onto one iob-native-style memory port.
//  It is the far end of the Versat AXI master path: it serves Versat external memory in

---
 rtl/versat_axi_responder.sv | 208 ++++++++++++++++++++
 tb/tb_versat_axi_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/versat_axi_responder.sv
// AXI4 subordinate that serialises one INCR/FIXED burst at a time onto a
// single iob-native memory port. Reads pass through a one-entry R register.
module versat_axi_responder #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ID_W-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [AXI_ID_W-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ID_W-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_ID_W-1:0]     s_axi_rid,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [AXI_ADDR_W-1:0]   mem_addr,
  output logic [AXI_DATA_W-1:0]   mem_wdata,
  output logic [AXI_DATA_W/8-1:0] mem_wstrb,
  input  logic [AXI_DATA_W-1:0]   mem_rdata
);
  localparam int BYTES = AXI_DATA_W / 8;
  localparam logic [AXI_ADDR_W-1:0] ADDR_INC  = AXI_ADDR_W'(BYTES);
  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~AXI_ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t                  state_q, state_d;
  logic                    prio_w_q, prio_w_d;
  logic [AXI_ID_W-1:0]     id_q, id_d;
  logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic                    fixed_q, fixed_d;
  logic                    err_q, err_d;
  logic [8:0]              cnt_q, cnt_d;
  logic                    rvalid_q, rvalid_d;
  logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    rlast_q, rlast_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [AXI_ID_W-1:0]     rid_q, rid_d;

  logic aw_acc, ar_acc, w_hs, mem_hs, r_hs, last_beat;
  logic [AXI_ADDR_W-1:0] next_addr;

  // Readies are qualified by rst so nothing looks accepted while held in reset.
  assign aw_acc    = rst && (state_q == IDLE) && s_axi_awvalid && (!s_axi_arvalid || prio_w_q);
  assign ar_acc    = rst && (state_q == IDLE) && s_axi_arvalid && (!s_axi_awvalid || !prio_w_q);
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  assign mem_hs    = mem_valid && mem_ready;
  assign r_hs      = rvalid_q && s_axi_rready;
  assign last_beat = (cnt_q == {1'b0, len_q});
  assign next_addr = fixed_q ? addr_q : addr_q + ADDR_INC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      prio_w_q <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rlast_q  <= 1'b0;
      rresp_q  <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_w_q <= prio_w_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      fixed_q  <= fixed_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      rresp_q  <= rresp_d;
      rid_q    <= rid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_w_d = prio_w_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    fixed_d  = fixed_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    rid_d    = rid_q;
    case (state_q)
      IDLE: begin
        if (aw_acc || ar_acc) begin
          prio_w_d = ~prio_w_q;
          cnt_d    = '0;
          if (aw_acc) begin
            id_d    = s_axi_awid;
            addr_d  = s_axi_awaddr & ADDR_MASK;
            len_d   = s_axi_awlen;
            fixed_d = (s_axi_awburst == 2'b00);
            err_d   = s_axi_awburst[1];
            state_d = WRITE;
          end else begin
            id_d    = s_axi_arid;
            addr_d  = s_axi_araddr & ADDR_MASK;
            len_d   = s_axi_arlen;
            fixed_d = (s_axi_arburst == 2'b00);
            err_d   = s_axi_arburst[1];
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (w_hs) begin
          // Beat count, not wlast, ends the burst; a disagreeing wlast only flags SLVERR.
          if (s_axi_wlast != last_beat) err_d = 1'b1;
          cnt_d  = cnt_q + 9'd1;
          addr_d = next_addr;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        if (s_axi_bready) state_d = IDLE;
      end
      READ: begin
        if (mem_hs) begin
          rvalid_d = 1'b1;
          rdata_d  = mem_rdata;
          rlast_d  = last_beat;
          rresp_d  = {err_q, 1'b0};
          rid_d    = id_q;
          cnt_d    = cnt_q + 9'd1;
          addr_d   = next_addr;
        end else if (r_hs) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
        end
        if (r_hs && rlast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = aw_acc;
    s_axi_arready = ar_acc;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = (state_q == WRESP);
    mem_valid     = 1'b0;
    mem_addr      = addr_q;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    case (state_q)
      WRITE: begin
        // Empty-strobe beats are swallowed without touching memory.
        s_axi_wready = (s_axi_wstrb == '0) || mem_ready;
        mem_valid    = s_axi_wvalid && (s_axi_wstrb != '0);
        mem_wdata    = s_axi_wdata;
        mem_wstrb    = s_axi_wstrb;
      end
      READ: begin
        // Fetch only when the R register is free or draining this cycle.
        mem_valid = (cnt_q <= {1'b0, len_q}) && (!rvalid_q || s_axi_rready);
      end
      default: ;
    endcase
  end

  assign s_axi_bid    = id_q;
  assign s_axi_bresp  = {err_q, 1'b0};
  assign s_axi_rid    = rid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rvalid = rvalid_q;

endmodule

// File: tb/tb_versat_axi_responder.sv
// Directed bench for versat_axi_responder: word memory model behind the mem
// port, write log, and hand-computed expectations for each burst.
module tb_versat_axi_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [0:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;
  logic        mem_valid, mem_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  versat_axi_responder dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] wlog_a [64];
  logic [31:0] wlog_d [64];
  int wn = 0, mrd = 0, rhs = 0, cyc = 0;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_valid && mem_ready && mem_wstrb != 4'h0) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wlog_a[wn] <= mem_addr;
      wlog_d[wn] <= mem_wdata;
      wn <= wn + 1;
    end
    if (mem_valid && mem_ready && mem_wstrb == 4'h0) mrd <= mrd + 1;
    if (rvalid && rready) rhs <= rhs + 1;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [0:0] id);
    int n = 0;
    @(negedge clk);
    awaddr = a; awlen = l; awburst = b; awid = id; awvalid = 1'b1;
    #1;
    while (!awready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("aw_timeout", 0, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b, input logic [0:0] id);
    int n = 0;
    @(negedge clk);
    araddr = a; arlen = l; arburst = b; arid = id; arvalid = 1'b1;
    #1;
    while (!arready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("ar_timeout", 0, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic w_send(input int l, input logic [31:0] base, input logic [3:0] s0, input logic [3:0] s1, input int wl_at);
    for (int i = 0; i <= l; i++) begin
      int n = 0;
      @(negedge clk);
      wdata = base + 32'(i); wstrb = (i == 0) ? s0 : s1; wlast = (i == wl_at); wvalid = 1'b1;
      #1;
      while (!wready && n < 50) begin @(negedge clk); #1; n++; end
      if (n >= 50) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_get(output logic [1:0] resp, output logic [0:0] id);
    int n = 0;
    @(negedge clk); bready = 1'b1; #1;
    while (!bvalid && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) chk("b_timeout", 0, 1);
    resp = bresp; id = bid;
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk); #1;
    chk("b_once", bvalid, 0);
  endtask

  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  int          rd_cyc  [16];
  int          rn, ahead_max = 0;

  task automatic r_get(input int nexp, input bit tog);
    int k = 0;
    bit stalled = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    rn = 0;
    while (rn < nexp && k < 200) begin
      @(negedge clk);
      rready = tog ? (k % 2 == 0) : 1'b1;
      #1;
      if (rvalid && stalled) chk("r_hold", {rdata, 31'd0, rlast}, {pd, 31'd0, pl});
      if (mrd - rhs > ahead_max) ahead_max = mrd - rhs;
      if (rvalid && rready) begin
        rd_data[rn] = rdata; rd_last[rn] = rlast; rd_resp[rn] = rresp; rd_cyc[rn] = cyc;
        rn++;
      end
      stalled = rvalid && !rready; pd = rdata; pl = rlast;
      @(posedge clk); #1;
      k++;
    end
    rready = 1'b0;
    chk("r_beats", rn, nexp);
  endtask

  logic [1:0] br;
  logic [0:0] bi;
  int w0;

  initial begin
    awvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_mem", {mem_valid, mem_wstrb}, 0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); rst = 1'b1;

    // INCR write 0x100 len 3, data 1..4
    w0 = wn;
    aw_send(32'h100, 8'd3, 2'b01, 1'b0);
    w_send(3, 32'd1, 4'hF, 4'hF, 3);
    b_get(br, bi);
    chk("incr_w_n", wn - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("incr_w_addr", wlog_a[w0+i], 32'h100 + 32'(4*i));
      chk("incr_w_data", wlog_d[w0+i], 32'(i+1));
    end
    chk("incr_w_bresp", br, 2'b00);

    // INCR read full rate
    ar_send(32'h100, 8'd3, 2'b01, 1'b0);
    r_get(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_r_data", rd_data[i], 32'(i+1));
      chk("incr_r_last", rd_last[i], i == 3);
      chk("incr_r_resp", rd_resp[i], 2'b00);
    end
    chk("incr_r_rate", rd_cyc[3] - rd_cyc[0], 3);

    // same read, rready 1,0,1,0
    ar_send(32'h100, 8'd3, 2'b01, 1'b0);
    r_get(4, 1'b1);
    for (int i = 0; i < 4; i++) chk("tog_r_data", rd_data[i], 32'(i+1));
    chk("tog_r_last", rd_last[3], 1);
    chk("tog_ahead", ahead_max, 1);

    // FIXED write len 1 at 0x20, strobe F then 0
    w0 = wn;
    aw_send(32'h20, 8'd1, 2'b00, 1'b0);
    w_send(1, 32'hA0, 4'hF, 4'h0, 1);
    b_get(br, bi);
    chk("fix_w_n", wn - w0, 1);
    chk("fix_w_addr", wlog_a[w0], 32'h20);
    chk("fix_w_data", wlog_d[w0], 32'hA0);
    chk("fix_w_bresp", br, 2'b00);

    // WRAP write/read: served as INCR with SLVERR
    w0 = wn;
    aw_send(32'h200, 8'd1, 2'b10, 1'b0);
    w_send(1, 32'hB0, 4'hF, 4'hF, 1);
    b_get(br, bi);
    chk("wrap_w_n", wn - w0, 2);
    chk("wrap_w_addr1", wlog_a[w0+1], 32'h204);
    chk("wrap_w_bresp", br, 2'b10);
    ar_send(32'h200, 8'd1, 2'b10, 1'b1);
    r_get(2, 1'b0);
    chk("wrap_r_data", {rd_data[0], rd_data[1]}, {32'hB0, 32'hB1});
    chk("wrap_r_resp", {rd_resp[0], rd_resp[1]}, 4'b1010);
    chk("wrap_r_last", {rd_last[0], rd_last[1]}, 2'b01);

    // wlast on beat 1 of a 2-beat write
    w0 = wn;
    aw_send(32'h300, 8'd1, 2'b01, 1'b1);
    w_send(1, 32'hC0, 4'hF, 4'hF, 0);
    b_get(br, bi);
    chk("early_last_n", wn - w0, 2);
    chk("early_last_bresp", br, 2'b10);
    chk("early_last_bid", bi, 1);

    // arbitration from reset: write, read, write
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    awaddr = 32'h40; awlen = 8'd0; awburst = 2'b01; awid = 1'b0; awvalid = 1'b1;
    araddr = 32'h100; arlen = 8'd0; arburst = 2'b01; arid = 1'b0; arvalid = 1'b1;
    #1;
    chk("arb1", {awready, arready}, 2'b10);
    @(posedge clk); #1 awvalid = 1'b0;
    w_send(0, 32'hD0, 4'hF, 4'hF, 0);
    b_get(br, bi);
    chk("arb1_bresp", br, 2'b00);
    awaddr = 32'h44; awvalid = 1'b1;
    #1;
    chk("arb2", {awready, arready}, 2'b01);
    @(posedge clk); #1 arvalid = 1'b0;
    r_get(1, 1'b0);
    chk("arb2_rdata", rd_data[0], 32'd1);
    arvalid = 1'b1;
    #1;
    chk("arb3", {awready, arready}, 2'b10);
    @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
    w_send(0, 32'hD1, 4'hF, 4'hF, 0);
    b_get(br, bi);
    chk("arb_mem", {mem[16], mem[17]}, {32'hD0, 32'hD1});

    // reset in the middle of a stalled read
    ar_send(32'h100, 8'd7, 2'b01, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_rvalid_pre", rvalid, 1);
    rst = 1'b0;
    #1;
    chk("mid_rvalid", rvalid, 0);
    chk("mid_mem_valid", mem_valid, 0);
    @(negedge clk); rst = 1'b1;
    #1 arvalid = 1'b1;
    #1;
    chk("mid_idle", arready, 1);
    arvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d exp 0", 1);
    $fatal(1, "timeout");
  end
endmodule
